// File: rtl/lgate_op_arbiter_if.sv
// Bus between the requesters and the shared bitwise logic unit arbiter.
// Carries per-requester request/opcode/operand vectors plus the grant and
// the tagged result. The res_err signal only exists when LGATE_ARB_ERR_EN
// is defined.
interface lgate_op_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] op;
    logic [W*NREQ-1:0] a_in;
    logic [W*NREQ-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [W-1:0]      res;
`ifdef LGATE_ARB_ERR_EN
    logic              res_err;

    modport master (output req, op, a_in, b_in,
                    input  gnt, busy, res_valid, res_id, res, res_err);
    modport slave  (input  req, op, a_in, b_in,
                    output gnt, busy, res_valid, res_id, res, res_err);
`else
    modport master (output req, op, a_in, b_in,
                    input  gnt, busy, res_valid, res_id, res);
    modport slave  (input  req, op, a_in, b_in,
                    output gnt, busy, res_valid, res_id, res);
`endif
endinterface

// File: rtl/lgate_op_arbiter.sv
// Round-robin arbiter sharing one W-bit bitwise logic unit among NREQ
// requesters. IDLE picks a winner and latches its opcode/operands; EXEC
// evaluates them one cycle later and returns the result tagged with the
// winner's id. Optional macro LGATE_ARB_ERR_EN makes opcode 7 illegal
// (result 0, res_err=1); without it opcode 7 passes operand A through.
module lgate_op_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    lgate_op_arbiter_if.slave    bus
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [2:0]        op_q, op_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              res_valid_q, res_valid_d;
    logic [IDW-1:0]    res_id_q, res_id_d;
    logic [W-1:0]      res_q, res_d;
`ifdef LGATE_ARB_ERR_EN
    logic              res_err_q, res_err_d;
`endif

    logic              win_found;
    logic [IDW-1:0]    win_idx;
    logic [NREQ-1:0]   win_gnt;
    logic [2:0]        win_op;
    logic [W-1:0]      win_a;
    logic [W-1:0]      win_b;

    // Bitwise logic unit; opcode 7 depends on whether error checking is built in.
    function automatic logic [W-1:0] lgate_eval(input logic [2:0] opc,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [W-1:0] r;
        case (opc)
            3'd0:    r = a & b;
            3'd1:    r = a ^ b;
            3'd2:    r = a | b;
            3'd3:    r = ~(a & b);
            3'd4:    r = ~(a | b);
            3'd5:    r = ~(a ^ b);
            3'd6:    r = ~a;
`ifdef LGATE_ARB_ERR_EN
            default: r = '0;
`else
            default: r = a;
`endif
        endcase
        return r;
    endfunction

    // Round-robin search: first set req bit starting at ptr, wrapping mod NREQ.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr_q) + k) % NREQ;
            if (!win_found && bus.req[IDW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDW'(cand);
            end
        end
    end

    // Select the winner's opcode/operands and build its one-hot grant.
    always_comb begin
        win_gnt = '0;
        win_op  = '0;
        win_a   = '0;
        win_b   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                win_gnt[i] = 1'b1;
                win_op     = bus.op[3*i +: 3];
                win_a      = bus.a_in[W*i +: W];
                win_b      = bus.b_in[W*i +: W];
            end
        end
    end

    // Next-state and output logic for the IDLE/EXEC controller.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        gnt_d       = '0;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_d       = res_q;
`ifdef LGATE_ARB_ERR_EN
        res_err_d   = res_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    op_d    = win_op;
                    a_d     = win_a;
                    b_d     = win_b;
                    id_d    = win_idx;
                    gnt_d   = win_gnt;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d       = lgate_eval(op_q, a_q, b_q);
                res_id_d    = id_q;
                res_valid_d = 1'b1;
`ifdef LGATE_ARB_ERR_EN
                res_err_d   = (op_q == 3'd7);
`endif
                ptr_d       = (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_q       <= '0;
`ifdef LGATE_ARB_ERR_EN
            res_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_q       <= res_d;
`ifdef LGATE_ARB_ERR_EN
            res_err_q   <= res_err_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q == EXEC);
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res       = res_q;
`ifdef LGATE_ARB_ERR_EN
    assign bus.res_err   = res_err_q;
`endif

endmodule

// File: doc/lgate_op_arbiter.md
Name: lgate_op_arbiter

Overview:
- Shares one W-bit bitwise logic unit (AND/XOR/OR/NAND/NOR/XNOR/NOT) between NREQ requesters.
- Round-robin arbitration.
- Latches the winner's operands and opcode, evaluates on the next cycle, and returns the result tagged with the requester id.
- Sits between lab-level requesters (switch/FSM clients) and the shared logic datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 4, operand/result width in bits.
- IDW, 2, requester id width; must equal clog2(NREQ), minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  request per requester; bit i = requester i.
- op  input  3*NREQ  opcode per requester; op[3i+2:3i] belongs to requester i.
- a_in  input  W*NREQ  operand A per requester, slice [W*i+W-1:W*i].
- b_in  input  W*NREQ  operand B per requester, same slicing.
- gnt  output  NREQ  registered one-hot grant, one-cycle pulse.
- busy  output  1  high while in EXEC.
- res_valid  output  1  one-cycle pulse when res/res_id are new.
- res_id  output  IDW  requester index that owns res.
- res  output  W  result.
- res_err  output  1  only when LGATE_ARB_ERR_EN is defined (see Optional Feature).

Behaviour:
- Opcode map:
  - 0 = a&b
  - 1 = a^b
  - 2 = a|b
  - 3 = ~(a&b)
  - 4 = ~(a|b)
  - 5 = ~(a^b)
  - 6 = ~a (b ignored)
  - 7 = see Optional Feature
- All ops are bitwise over W bits. No carries, no width growth.
- Reset (rst sampled high at a clk edge):
  - state=IDLE; gnt=0, busy=0, res_valid=0, res_id=0, res=0, res_err=0.
  - rr pointer=0; latched op/a/b/id cleared.
- Reset overrides everything, including an in-flight EXEC; the aborted operation never produces res_valid.
- FSM has two states, IDLE and EXEC.
- IDLE:
  - If req==0: stay in IDLE; gnt=0, res_valid=0.
  - Otherwise: winner = first set req bit scanning ptr, ptr+1, ..., wrapping mod NREQ.
  - At the edge: latch winner's op/a/b and id; gnt <= onehot(winner); state <= EXEC.
- EXEC (exactly one cycle):
  - At the edge: res <= f(op,a,b); res_id <= id; res_valid <= 1.
  - Also: gnt <= 0; ptr <= (id+1) mod NREQ; state <= IDLE.
- busy = (state==EXEC), driven from the state register.
- Latency and throughput:
  - Request sampled at edge N.
  - gnt visible after edge N, for one cycle.
  - res_valid visible after edge N+1, for one cycle.
  - Maximum throughput: one operation per 2 cycles.
- Requester handshake:
  - Operands/opcode are sampled only at the granting edge; they may change afterwards.
  - A requester that keeps req high after its gnt is treated as a new request and re-arbitrated in the next IDLE. Round-robin guarantees others are served first.
- res and res_id hold their value between res_valid pulses.
- req changes during EXEC are ignored until the following IDLE cycle.
- Pointer wrap: a grant to NREQ-1 sets ptr to 0.
- Single requester continuously asserting: granted every 2 cycles.
- Upper operand bits are not masked; only the W-bit slice is used.

Optional Feature:
- Macro LGATE_ARB_ERR_EN.
- Defined:
  - Opcode 7 is illegal: res <= 0 and res_err <= 1, both with res_valid.
  - res_err is 0 for legal ops, and reset to 0.
  - Port res_err exists.
- Undefined:
  - Opcode 7 = pass-through: res <= a.
  - No res_err port, no error logic.

Test Plan (W=4, NREQ=4):
- Reset: hold rst high 2 cycles with req=4'b1111 → gnt=0, busy=0, res_valid=0, res=0, res_id=0 throughout. After release, first gnt=4'b0001.
- Single op: req=0001, op0=0, a0=4'b1100, b0=4'b1010 → gnt=0001 one cycle after sampling edge; next cycle res_valid=1, res=4'b1000, res_id=0. Repeat with op0=1,2,3,4,5 → 0110, 1110, 0111, 0001, 1001.
- NOT op: req=0100, op2=6, a2=4'b0101, b2=4'b1111 → res=4'b1010, res_id=2.
- Round-robin fairness: req=1111 held for 10 cycles → gnt sequence 0001, 0100? no: 0001, 0010, 0100, 1000, 0001 on alternating cycles; res_id sequence 0, 1, 2, 3, 0.
- Mid-operation reset: req=0010; assert rst in the EXEC cycle → no res_valid pulse; ptr=0. With req=1010 after release, next gnt=0010.
- Opcode 7, a=4'b0110, b=0:
  - With LGATE_ARB_ERR_EN → res=0, res_err=1.
  - Without → res=4'b0110.
